// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: time-shares one 32-bit magnitude comparator among NUM_REQ
// requesters. Round-robin grant in IDLE, operands registered on the handshake,
// result registered in CMP, and the result is held in RESP until the granted
// requester consumes it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[i]          requester i has a compare pending
//   req_a/req_b           operands, requester i at [32*i+31:32*i]
//   req_sign[i]           1 = two's-complement compare, 0 = unsigned
//   req_ready[i]          one-hot grant, valid in IDLE only (combinational)
//   rsp_valid[i]          one-hot, result for requester i is present
//   rsp_ready[i]          requester i consumes its result
//   rsp_gr/rsp_lt/rsp_eq  A>B / A<B / A==B, all zero when no result is present
//   busy                  a compare is in flight (CMP or RESP)
module cmp_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_sign,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic                    rsp_gr,
  output logic                    rsp_lt,
  output logic                    rsp_eq,
  output logic                    busy
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, id_q, win_c, rr_next_c;
  logic                found_c, accept_c, done_c;
  int unsigned         scan_idx;
  logic [DATA_W-1:0]   sel_a_c, sel_b_c;
  logic                sel_sign_c;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                sign_q;
  logic [DATA_W-1:0]   a_key_c, b_key_c;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    found_c  = 1'b0;
    win_c    = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = 32'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found_c && req_valid[ID_W'(scan_idx)]) begin
        found_c = 1'b1;
        win_c   = ID_W'(scan_idx);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a_c    = '0;
    sel_b_c    = '0;
    sel_sign_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_c == ID_W'(i)) begin
        sel_a_c    = req_a[DATA_W*i +: DATA_W];
        sel_b_c    = req_b[DATA_W*i +: DATA_W];
        sel_sign_c = req_sign[i];
      end
    end
  end

  // Flipping the MSB maps two's-complement order onto unsigned order.
  assign a_key_c   = {a_q[DATA_W-1] ^ sign_q, a_q[DATA_W-2:0]};
  assign b_key_c   = {b_q[DATA_W-1] ^ sign_q, b_q[DATA_W-2:0]};
  assign rr_next_c = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(id_q + 1'b1);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state, grant and handshake strobes.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept_c  = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          req_ready[win_c] = 1'b1;
          accept_c         = 1'b1;
          state_d          = CMP;
        end
      end
      CMP: state_d = RESP;
      RESP: begin
        // Only the granted requester's rsp_ready matters.
        if (rsp_ready[id_q]) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, result register, response and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      id_q      <= '0;
      rr_ptr_q  <= '0;
      rsp_valid <= '0;
      rsp_gr    <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_eq    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (accept_c) begin
        a_q    <= sel_a_c;
        b_q    <= sel_b_c;
        sign_q <= sel_sign_c;
        id_q   <= win_c;
      end
      if (state_q == CMP) begin
        rsp_valid <= NUM_REQ'(1) << id_q;
        rsp_gr    <= (a_key_c > b_key_c);
        rsp_lt    <= (a_key_c < b_key_c);
        rsp_eq    <= (a_key_c == b_key_c);
      end
      if (done_c) begin
        rsp_valid <= '0;
        rsp_gr    <= 1'b0;
        rsp_lt    <= 1'b0;
        rsp_eq    <= 1'b0;
        rr_ptr_q  <= rr_next_c;
      end
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter with two requesters.
module tb_cmp_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_sign, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic        rsp_gr, rsp_lt, rsp_eq, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmp_share_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_sign(req_sign),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_gr(rsp_gr), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] oh(input int id);
    return 2'(1 << id);
  endfunction

  // Independent reference: {gr, lt, eq}.
  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (s) return {$signed(a) > $signed(b), $signed(a) < $signed(b), a == b};
    return {a > b, a < b, a == b};
  endfunction

  // One lone request from an idle arbiter; samples at accept, CMP, RESP and after.
  task automatic xact(input int id, input logic [31:0] a, input logic [31:0] b, input logic s,
                      output logic [1:0] rdy, output logic [1:0] rv_cmp, output logic busy_cmp,
                      output logic [1:0] rv_rsp, output logic [2:0] res,
                      output logic [1:0] rv_after, output logic [2:0] res_after);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_sign[id]       = s;
    req_valid          = oh(id);
    rsp_ready          = 2'b00;
    #1 rdy = req_ready;
    tick;
    req_valid = 2'b00;
    req_a     = {$urandom, $urandom};
    req_b     = {$urandom, $urandom};
    req_sign  = ~req_sign;
    #1 rv_cmp = rsp_valid;
    busy_cmp  = busy;
    tick;
    rv_rsp = rsp_valid;
    res    = {rsp_gr, rsp_lt, rsp_eq};
    rsp_ready = oh(id);
    tick;
    rsp_ready = 2'b00;
    rv_after  = rsp_valid;
    res_after = {rsp_gr, rsp_lt, rsp_eq};
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_sign = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_gr, rsp_lt, rsp_eq, busy} !== 8'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {req_ready, rsp_valid, rsp_gr, rsp_lt, rsp_eq, busy});
    end
    @(negedge clk) rst_n = 1'b1;
    tick;
  endtask

  // Drives a table of lone requests and checks latency, one-hot response and result.
  task automatic run_table(input string tag, input int n, input int ids[8],
                           input logic [31:0] as[8], input logic [31:0] bs[8],
                           input logic ss[8], input logic [2:0] exps[8]);
    logic [1:0] rdy, rv_cmp, rv_rsp, rv_after;
    logic [2:0] res, res_after;
    logic       busy_cmp;
    for (int k = 0; k < n; k++) begin
      xact(ids[k], as[k], bs[k], ss[k], rdy, rv_cmp, busy_cmp, rv_rsp, res, rv_after, res_after);
      total++;
      if (rdy !== oh(ids[k])) begin bad++; $display("FAIL %s[%0d] req_ready: got %b want %b", tag, k, rdy, oh(ids[k])); end
      total++;
      if ({rv_cmp, busy_cmp} !== 3'b001) begin bad++; $display("FAIL %s[%0d] cmp_cycle: got %b want 001", tag, k, {rv_cmp, busy_cmp}); end
      total++;
      if (rv_rsp !== oh(ids[k])) begin bad++; $display("FAIL %s[%0d] rsp_valid: got %b want %b", tag, k, rv_rsp, oh(ids[k])); end
      total++;
      if (res !== exps[k]) begin bad++; $display("FAIL %s[%0d] result gr/lt/eq: got %b want %b", tag, k, res, exps[k]); end
      total++;
      if ({rv_after, res_after} !== 5'b0) begin bad++; $display("FAIL %s[%0d] after_consume: got %b want 00000", tag, k, {rv_after, res_after}); end
    end
  endtask

  task automatic test_unsigned;
    int ids[8]; logic [31:0] as[8], bs[8]; logic ss[8]; logic [2:0] ex[8];
    ids[0] = 0; as[0] = 32'hFFFF_FFFF; bs[0] = 32'h0000_0001; ss[0] = 1'b0; ex[0] = 3'b100;
    ids[1] = 0; as[1] = 32'hFFFF_FFFF; bs[1] = 32'h0000_0001; ss[1] = 1'b1; ex[1] = 3'b010;
    run_table("unsigned", 2, ids, as, bs, ss, ex);
  endtask

  task automatic test_signed;
    int ids[8]; logic [31:0] as[8], bs[8]; logic ss[8]; logic [2:0] ex[8];
    ids[0] = 1; as[0] = 32'h8000_0000; bs[0] = 32'h7FFF_FFFF; ss[0] = 1'b1; ex[0] = 3'b010;
    ids[1] = 0; as[1] = 32'hFFFF_FFFE; bs[1] = 32'hFFFF_FFFF; ss[1] = 1'b1; ex[1] = 3'b010;
    ids[2] = 1; as[2] = 32'h1234_5678; bs[2] = 32'h1234_5678; ss[2] = 1'b1; ex[2] = 3'b001;
    ids[3] = 0; as[3] = 32'h8000_0000; bs[3] = 32'h7FFF_FFFF; ss[3] = 1'b0; ex[3] = 3'b100;
    ids[4] = 1; as[4] = 32'h0000_0005; bs[4] = 32'hFFFF_FFFB; ss[4] = 1'b1; ex[4] = 3'b100;
    run_table("signed", 5, ids, as, bs, ss, ex);
  endtask

  // Both requesters always valid and always ready: grants alternate from rr_ptr=0.
  task automatic test_fairness;
    logic [1:0] grants[8], rvs[8];
    logic [2:0] rss[8];
    int ng = 0, nr = 0;
    req_a = {32'd3, 32'd1}; req_b = {32'd3, 32'd2}; req_sign = 2'b00;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != 2'b00 && ng < 8) begin grants[ng] = req_ready; ng++; end
      if (rsp_valid != 2'b00 && nr < 8) begin rvs[nr] = rsp_valid; rss[nr] = {rsp_gr, rsp_lt, rsp_eq}; nr++; end
      tick;
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    total++;
    if (ng !== 4 || nr !== 4) begin bad++; $display("FAIL fair_counts: got grants=%0d rsps=%0d want 4 4", ng, nr); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (grants[k] !== oh(k % 2)) begin bad++; $display("FAIL fair_grant[%0d]: got %b want %b", k, grants[k], oh(k % 2)); end
      total++;
      if (rvs[k] !== oh(k % 2)) begin bad++; $display("FAIL fair_rsp_valid[%0d]: got %b want %b", k, rvs[k], oh(k % 2)); end
      total++;
      if (rss[k] !== ((k % 2 == 0) ? 3'b010 : 3'b001)) begin
        bad++; $display("FAIL fair_result[%0d]: got %b want %b", k, rss[k], (k % 2 == 0) ? 3'b010 : 3'b001);
      end
    end
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL fair_idle_busy: got %b want 0", busy); end
  endtask

  // Result held while the owner stalls; other requester's ready and valid ignored.
  task automatic test_backpressure;
    req_a[63:32] = 32'd7; req_b[63:32] = 32'd9; req_sign = 2'b00;
    req_valid = 2'b10; rsp_ready = 2'b00;
    tick;
    req_valid = 2'b00;
    tick;
    req_a[31:0] = 32'h0000_000A; req_b[31:0] = 32'h0000_0003;
    req_valid = 2'b01; rsp_ready = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({rsp_valid, rsp_gr, rsp_lt, rsp_eq, req_ready, busy} !== 8'b10_010_00_1) begin
        bad++; $display("FAIL bp_hold[%0d] rv,gr,lt,eq,rdy,busy: got %b want 10010001", c,
                        {rsp_valid, rsp_gr, rsp_lt, rsp_eq, req_ready, busy});
      end
      tick;
    end
    rsp_ready = 2'b10;
    tick;
    rsp_ready = 2'b00;
    total++;
    if ({rsp_valid, req_ready} !== 4'b00_01) begin
      bad++; $display("FAIL bp_release rv,rdy: got %b want 0001", {rsp_valid, req_ready});
    end
    tick;
    req_valid = 2'b00;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL bp_accept_busy: got %b want 1", busy); end
    tick;
    total++;
    if ({rsp_valid, rsp_gr, rsp_lt, rsp_eq} !== 5'b01_100) begin
      bad++; $display("FAIL bp_next_rsp: got %b want 01100", {rsp_valid, rsp_gr, rsp_lt, rsp_eq});
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Random traffic against a cycle-level scoreboard; rr_ptr starts at 1 here.
  task automatic test_random;
    int rr_exp = 1, pid = 0, age = 0, acc = 0, done = 0, win;
    bit pend = 1'b0, was_pend;
    logic [2:0] pres = '0;
    logic [1:0] exp_rdy;
    for (int c = 0; c < 10000; c++) begin
      if (pend) age++;
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      req_sign  = 2'($urandom);
      req_a = {rnd32(), rnd32()};
      req_b = ($urandom_range(0, 4) == 0) ? req_a : {rnd32(), rnd32()};
      #1;
      was_pend = pend;
      total++;
      if (busy !== was_pend) begin bad++; $display("FAIL rnd_busy @%0d: got %b want %b", c, busy, was_pend); end
      if (pend && age >= 2) begin
        total++;
        if ({rsp_valid, rsp_gr, rsp_lt, rsp_eq} !== {oh(pid), pres}) begin
          bad++; $display("FAIL rnd_rsp @%0d: got %b want %b", c, {rsp_valid, rsp_gr, rsp_lt, rsp_eq}, {oh(pid), pres});
        end
        if (rsp_ready[pid]) begin
          done++; pend = 1'b0; rr_exp = (pid + 1) % 2;
        end
      end else begin
        total++;
        if ({rsp_valid, rsp_gr, rsp_lt, rsp_eq} !== 5'b0) begin
          bad++; $display("FAIL rnd_no_rsp @%0d: got %b want 00000", c, {rsp_valid, rsp_gr, rsp_lt, rsp_eq});
        end
      end
      if (!was_pend && req_valid != 2'b00) begin
        win = req_valid[rr_exp] ? rr_exp : 1 - rr_exp;
        exp_rdy = oh(win);
      end else begin
        win = 0;
        exp_rdy = 2'b00;
      end
      total++;
      if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_grant @%0d: got %b want %b", c, req_ready, exp_rdy); end
      if (exp_rdy != 2'b00) begin
        acc++; pend = 1'b1; age = 0; pid = win;
        pres = ref_cmp(req_a[32*win +: 32], req_b[32*win +: 32], req_sign[win]);
      end
      tick;
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    for (int c = 0; c < 4 && busy; c++) tick;
    rsp_ready = 2'b00;
    if (pend) done++;
    total++;
    if (acc !== done || acc < 100) begin bad++; $display("FAIL rnd_conservation: accepted=%0d completed=%0d", acc, done); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rnd_drain_busy: got %b want 0", busy); end
  endtask

  // Reset while requester 1 sits in RESP with rr_ptr=1; afterwards req0 must win.
  task automatic test_reset_mid;
    logic [1:0] rdy, rv_cmp, rv_rsp, rv_after;
    logic [2:0] res, res_after;
    logic       busy_cmp;
    xact(0, 32'd1, 32'd1, 1'b0, rdy, rv_cmp, busy_cmp, rv_rsp, res, rv_after, res_after);
    total++;
    if (res !== 3'b001) begin bad++; $display("FAIL rstmid_pre result: got %b want 001", res); end
    req_a[63:32] = 32'd100; req_b[63:32] = 32'd1; req_sign = 2'b00; req_valid = 2'b10;
    tick;
    req_valid = 2'b00;
    tick;
    total++;
    if (rsp_valid !== 2'b10) begin bad++; $display("FAIL rstmid_in_resp: got %b want 10", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_gr, rsp_lt, rsp_eq, busy} !== 8'b0) begin
      bad++; $display("FAIL rstmid_async_clear: got %b want 00000000",
                      {req_ready, rsp_valid, rsp_gr, rsp_lt, rsp_eq, busy});
    end
    @(negedge clk) rst_n = 1'b1;
    req_a = {32'd5, 32'd2}; req_b = {32'd5, 32'd9}; req_sign = 2'b00; req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rstmid_rr_restart: got %b want 01", req_ready); end
    tick;
    req_valid = 2'b00;
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rstmid_no_stale_rsp: got %b want 00", rsp_valid); end
    tick;
    total++;
    if ({rsp_valid, rsp_gr, rsp_lt, rsp_eq} !== 5'b01_010) begin
      bad++; $display("FAIL rstmid_next_rsp: got %b want 01010", {rsp_valid, rsp_gr, rsp_lt, rsp_eq});
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_fairness();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
